booth_seq_mul: RTL and testbench

Multi-cycle radix-2 Booth multiplier that sequences one add/subtract-and-shift Booth step per clock over a shared product register. It takes the place of the fully unrolled 32-stage Booth array where area matters more than latency. It serves the CPU's MULT path through a valid/ready request port and a valid/ready result port. It returns the full signed product, the truncated low word, and a signed overflow flag.

---
 rtl/mul_pkg.sv | 19 +
 rtl/booth_step.sv | 22 ++
 rtl/booth_seq_mul.sv | 121 ++++++++++++
 tb/tb_booth_seq_mul.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared state type, counter-width helper and overflow check for the multiplier family
package mul_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

    // Counter width able to hold the values 0..width
    function automatic int BOOTH_CNT_W(input int width);
        return $clog2(width + 1);
    endfunction

    // p is the product sign-extended to 128 bits; it fits in w signed bits
    // only if bits [2w-1:w-1] agree, i.e. p >>> (w-1) is 0 or -1
    function automatic logic ovf_check(input logic [127:0] p, input int w);
        logic signed [127:0] t;
        t = $signed(p) >>> (w - 1);
        return !((t == '0) || (&t));
    endfunction

endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth step (pair decode, add/sub, arithmetic shift right by 1)
module booth_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH+1:0] p_i,
    input  logic [WIDTH:0]     a_i,
    input  logic [WIDTH:0]     s_i,
    output logic [2*WIDTH+1:0] p_o
);

    logic [2*WIDTH+1:0] addend;
    logic [2*WIDTH+1:0] sum;

    // Pair 01 adds A, pair 10 adds S (=-A), 00/11 leave P; carry out is dropped
    always_comb begin
        addend = (p_i[1:0] == 2'b01) ? {a_i, {(WIDTH+1){1'b0}}} :
                 (p_i[1:0] == 2'b10) ? {s_i, {(WIDTH+1){1'b0}}} : '0;
        sum    = p_i + addend;
        p_o    = {sum[2*WIDTH+1], sum[2*WIDTH+1:1]};
    end

endmodule

// File: rtl/booth_seq_mul.sv
// booth_seq_mul: sequential radix-2 Booth multiplier, one step per clock; optional BOOTH_EARLY_EXIT_EN
module booth_seq_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   m,
    input  logic [WIDTH-1:0]   r,
    input  logic               kill,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] prod,
    output logic [WIDTH-1:0]   ans,
    output logic               overflow,
    output logic               busy
);

    localparam int PW = 2*WIDTH + 2;
    localparam int CW = BOOTH_CNT_W(WIDTH);

    mul_state_t       state_q, state_d;
    logic [PW-1:0]    p_q, p_d, p_step;
    logic [WIDTH:0]   a_q, a_d, s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept, last;

    assign in_ready  = (state_q == IDLE) && !kill;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign accept    = in_valid && in_ready;
    assign last      = (cnt_q == CW'(WIDTH - 1));
    assign prod      = p_q[2*WIDTH:1];
    assign ans       = prod[WIDTH-1:0];
    assign overflow  = ovf_check(128'($signed(prod)), WIDTH);

    booth_step #(.WIDTH(WIDTH)) u_step (
        .p_i (p_q),
        .a_i (a_q),
        .s_i (s_q),
        .p_o (p_step)
    );

`ifdef BOOTH_EARLY_EXIT_EN
    logic [CW:0]   rem;
    logic [PW-1:0] lo_mask, lo_bits, p_exit;
    logic          early;

    // Uniform P[WIDTH-c:0] means every remaining pair is 00/11: finish with one wide shift
    always_comb begin
        rem     = (CW+1)'(WIDTH) - (CW+1)'(cnt_q);
        lo_mask = ~({PW{1'b1}} << (rem + (CW+1)'(1)));
        lo_bits = p_q & lo_mask;
        early   = (lo_bits == '0) || (lo_bits == lo_mask);
        p_exit  = $signed(p_q) >>> rem;
    end
`else
    logic          early;
    logic [PW-1:0] p_exit;
    assign early  = 1'b0;
    assign p_exit = p_step;
`endif

    // Controller next state; kill overrides accept and completion
    always_comb begin
        state_d = state_q;
        if (kill)
            state_d = IDLE;
        else
            case (state_q)
                IDLE:    state_d = in_valid ? RUN : IDLE;
                RUN:     state_d = (last || early) ? DONE : RUN;
                DONE:    state_d = out_ready ? IDLE : DONE;
                default: state_d = IDLE;
            endcase
    end

    // Datapath next state: load operands on accept, one Booth step per RUN cycle
    always_comb begin
        p_d   = p_q;
        a_d   = a_q;
        s_d   = s_q;
        cnt_d = cnt_q;
        if (accept) begin
            a_d   = {m[WIDTH-1], m};
            s_d   = -{m[WIDTH-1], m};
            p_d   = {{(WIDTH+1){1'b0}}, r, 1'b0};
            cnt_d = '0;
        end else if (state_q == RUN) begin
            p_d   = early ? p_exit : p_step;
            cnt_d = cnt_q + CW'(1);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q   <= '0;
            a_q   <= '0;
            s_q   <= '0;
            cnt_q <= '0;
        end else begin
            p_q   <= p_d;
            a_q   <= a_d;
            s_q   <= s_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_booth_seq_mul.sv
// tb_booth_seq_mul: directed scoreboard bench for booth_seq_mul (WIDTH=32)
module tb_booth_seq_mul;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] m = '0;
    logic [31:0] r = '0;
    logic        kill = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] prod;
    logic [31:0] ans;
    logic        overflow;
    logic        busy;

    int checks = 0;
    int errors = 0;

`ifdef BOOTH_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    typedef struct {
        logic [63:0] p;
        logic        o;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        logic [31:0] m;
        logic [31:0] r;
        logic [63:0] p;
        logic        o;
        int          lat;
    } vec_t;

    booth_seq_mul #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .m         (m),
        .r         (r),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod),
        .ans       (ans),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: pop and compare on every result handshake
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", prod, 64'hx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("prod", prod, e.p);
                chk("ans", {32'h0, ans}, {32'h0, e.p[31:0]});
                chk("overflow", {63'h0, overflow}, {63'h0, e.o});
            end
        end
    end

    // Issue one request, push its expectation, measure latency; lat < 0 skips the latency check
    task automatic run(input logic [31:0] mm, input logic [31:0] rr,
                       input logic [63:0] ep, input logic eo, input int lat_exp);
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_before_req", {63'h0, in_ready}, 64'h1);
        in_valid = 1'b1;
        m = mm;
        r = rr;
        exp_q.push_back('{p: ep, o: eo});
        @(posedge clk); #1;
        in_valid = 1'b0;
        m = $urandom;
        r = $urandom;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("out_valid_seen", {63'h0, out_valid}, 64'h1);
        chk("in_ready_in_done", {63'h0, in_ready}, 64'h0);
        if (lat_exp >= 0) chk("latency", 64'(lat), 64'(lat_exp));
        while (out_valid && !out_ready) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk("in_ready_after_take", {63'h0, in_ready}, 64'h1);
        chk("out_valid_after_take", {63'h0, out_valid}, 64'h0);
    endtask

    vec_t vecs[12] = '{
        '{32'd3,         32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 32},
        '{32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1, 32},
        '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1, 32},
        '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b1, 32},
        '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 32},
        '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1, 32},
        '{32'hFFFF_FFFD, 32'd0,         64'h0,                   1'b0, 32},
        '{32'h0000_FFFF, 32'h0000_8000, 64'h0000_0000_7FFF_8000, 1'b0, 32},
        '{32'h0001_0000, 32'h0000_8000, 64'h0000_0000_8000_0000, 1'b1, 32},
        '{32'hFFFF_0000, 32'h0000_8000, 64'hFFFF_FFFF_8000_0000, 1'b0, 32},
        '{32'd9,         32'd1,         64'd9,                   1'b0, EE ? 3 : 32},
        '{32'hFFFF_FFFC, 32'd0,         64'd0,                   1'b0, EE ? 1 : 32}
    };

    initial begin
        #2;
        chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_prod", prod, 64'h0);
        chk("rst_overflow", {63'h0, overflow}, 64'h0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        kill = 1'b1;
        #1 chk("kill_gates_in_ready", {63'h0, in_ready}, 64'h0);
        kill = 1'b0;
        #1 chk("in_ready_after_kill_idle", {63'h0, in_ready}, 64'h1);

        foreach (vecs[i])
            run(vecs[i].m, vecs[i].r, vecs[i].p, vecs[i].o,
                (EE && vecs[i].lat == 32) ? -1 : vecs[i].lat);

        // Result held while the consumer stalls
        out_ready = 1'b0;
        in_valid = 1'b1;
        m = 32'hFFFF_FFF9;
        r = 32'd100;
        exp_q.push_back('{p: 64'hFFFF_FFFF_FFFF_FD44, o: 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int n = 0; n < 200 && !out_valid; n++) begin
            @(posedge clk); #1;
        end
        for (int k = 0; k < 10; k++) begin
            chk("hold_out_valid", {63'h0, out_valid}, 64'h1);
            chk("hold_prod", prod, 64'hFFFF_FFFF_FFFF_FD44);
            chk("hold_in_ready", {63'h0, in_ready}, 64'h0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_release", {63'h0, in_ready}, 64'h1);

        // Kill mid-run, then a fresh request must complete normally
        in_valid = 1'b1;
        m = 32'd5;
        r = 32'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 kill = 1'b1;
        chk("busy_before_kill", {63'h0, busy}, 64'h1);
        @(posedge clk); #1;
        kill = 1'b0;
        chk("busy_after_kill", {63'h0, busy}, 64'h0);
        chk("out_valid_after_kill", {63'h0, out_valid}, 64'h0);
        run(32'd7, 32'd6, 64'd42, 1'b0, EE ? -1 : 32);

        // Asynchronous reset mid-run
        in_valid = 1'b1;
        m = 32'h1234_5678;
        r = 32'h0FED_CBA9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", {63'h0, in_ready}, 64'h1);
        chk("arst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("arst_busy", {63'h0, busy}, 64'h0);
        chk("arst_prod", prod, 64'h0);
        chk("arst_ans", {32'h0, ans}, 64'h0);
        chk("arst_overflow", {63'h0, overflow}, 64'h0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run(32'hFFFF_FFF8, 32'd3, 64'hFFFF_FFFF_FFFF_FFE8, 1'b0, EE ? -1 : 32);

        repeat (3) @(posedge clk);
        #1 chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
